// File: rtl/io_reg_pipe_if.sv
// io_reg_pipe bus: enable/flush/data toward the pipe, data/status back.
// master drives CE, FLUSH, D, D_VLD; slave drives Q, Q_VLD, FULL, FILL (+PERR with IO_REG_PIPE_PARITY_EN).
interface io_reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int FW = $clog2(DEPTH + 1);

  logic             CE;
  logic             FLUSH;
  logic [WIDTH-1:0] D;
  logic             D_VLD;
  logic [WIDTH-1:0] Q;
  logic             Q_VLD;
  logic             FULL;
  logic [FW-1:0]    FILL;
`ifdef IO_REG_PIPE_PARITY_EN
  logic             PERR;
`endif

  modport master (
    output CE, FLUSH, D, D_VLD,
`ifdef IO_REG_PIPE_PARITY_EN
    input  PERR,
`endif
    input  Q, Q_VLD, FULL, FILL
  );

  modport slave (
    input  CE, FLUSH, D, D_VLD,
`ifdef IO_REG_PIPE_PARITY_EN
    output PERR,
`endif
    output Q, Q_VLD, FULL, FILL
  );
endinterface

// File: rtl/io_reg_pipe.sv
// WIDTH x DEPTH IO register pipe with CE, sync FLUSH, per-beat valid and fill count.
// Ports: CLK, RST (async, high), bus (slave). Macro IO_REG_PIPE_PARITY_EN adds parity + PERR.
module io_reg_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         CLK,
  input logic         RST,
  io_reg_pipe_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0]            vld;
  logic [FW-1:0]               fill;
  logic [FW-1:0]               fill_nxt;

  // Beats in and out cancel; intermediate wrap is harmless in modulo arithmetic.
  always_comb begin
    fill_nxt = fill + FW'(bus.D_VLD) - FW'(vld[DEPTH-1]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dat  <= {DEPTH{RST_VAL}};
      vld  <= '0;
      fill <= '0;
    end else if (bus.FLUSH) begin
      dat  <= {DEPTH{RST_VAL}};
      vld  <= '0;
      fill <= '0;
    end else if (bus.CE) begin
      dat[0] <= bus.D;
      vld[0] <= bus.D_VLD;
      for (int i = 1; i < DEPTH; i++) begin
        dat[i] <= dat[i-1];
        vld[i] <= vld[i-1];
      end
      fill <= fill_nxt;
    end
  end

  assign bus.Q     = dat[DEPTH-1];
  assign bus.Q_VLD = vld[DEPTH-1];
  assign bus.FILL  = fill;
  assign bus.FULL  = (fill == FW'(DEPTH));

`ifdef IO_REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par <= '0;
    end else if (bus.FLUSH) begin
      par <= '0;
    end else if (bus.CE) begin
      par[0] <= bus.D_VLD & (^bus.D);
      for (int i = 1; i < DEPTH; i++) begin
        par[i] <= par[i-1];
      end
    end
  end

  // Q_VLD gating keeps PERR low after reset/flush and for idle beats.
  assign bus.PERR = vld[DEPTH-1] & ((^dat[DEPTH-1]) != par[DEPTH-1]);
`endif
endmodule

// File: tb/tb_io_reg_pipe.sv
// Directed bench for io_reg_pipe, WIDTH=8, DEPTH=2, RST_VAL=8'h3C.
// Checks reset, latency, fill, hold, flush, async reset and (with macro) parity.
module tb_io_reg_pipe;
  localparam int               W  = 8;
  localparam int               DP = 2;
  localparam logic [W-1:0]     RV = 8'h3C;

  logic CLK = 1'b0;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  io_reg_pipe_if #(.WIDTH(W), .DEPTH(DP)) bus ();

  io_reg_pipe #(.WIDTH(W), .DEPTH(DP), .RST_VAL(RV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic st(input string tag, input logic [W-1:0] q,
                    input logic qv, input int f);
    chk({tag, ".q"}, 32'(bus.Q), 32'(q));
    chk({tag, ".qv"}, 32'(bus.Q_VLD), 32'(qv));
    chk({tag, ".fill"}, 32'(bus.FILL), 32'(f));
    chk({tag, ".full"}, 32'(bus.FULL), 32'(f == DP));
`ifdef IO_REG_PIPE_PARITY_EN
    chk({tag, ".perr"}, 32'(bus.PERR), 32'd0);
`endif
  endtask

  task automatic drv(input logic ce, input logic fl,
                     input logic [W-1:0] d, input logic dv);
    bus.CE    = ce;
    bus.FLUSH = fl;
    bus.D     = d;
    bus.D_VLD = dv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    st("rst", RV, 1'b0, 0);
    #9;
    RST = 1'b0;
    #1;

    // single beat latency
    drv(1'b1, 1'b0, 8'hA5, 1'b1);
    step;
    st("lat1", RV, 1'b0, 1);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    step;
    st("lat2", 8'hA5, 1'b1, 1);
    step;
    st("lat3", 8'h00, 1'b0, 0);

    // continuous stream
    drv(1'b1, 1'b0, 8'h11, 1'b1);
    step;
    st("str1", 8'h00, 1'b0, 1);
    bus.D = 8'h22;
    step;
    st("str2", 8'h11, 1'b1, 2);
    bus.D = 8'h33;
    step;
    st("str3", 8'h22, 1'b1, 2);
    bus.D = 8'h44;
    step;
    st("str4", 8'h33, 1'b1, 2);

    // hold with CE low while D toggles
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 1'b0, 8'(8'hF0 ^ (i * 8'h1F)), 1'(i));
      step;
      st("hold", 8'h33, 1'b1, 2);
    end
    drv(1'b1, 1'b0, 8'h55, 1'b0);
    step;
    st("resume", 8'h44, 1'b1, 1);

    // refill then flush with CE low
    drv(1'b1, 1'b0, 8'h66, 1'b1);
    step;
    st("rf1", 8'h55, 1'b0, 1);
    bus.D = 8'h77;
    step;
    st("rf2", 8'h66, 1'b1, 2);
    drv(1'b0, 1'b1, 8'h88, 1'b1);
    step;
    st("flush", RV, 1'b0, 0);
    drv(1'b1, 1'b1, 8'h99, 1'b1);
    step;
    st("fl_drop", RV, 1'b0, 0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    step;
    st("fl_post1", RV, 1'b0, 0);
    step;
    st("fl_post2", 8'h00, 1'b0, 0);

`ifdef IO_REG_PIPE_PARITY_EN
    drv(1'b1, 1'b0, 8'hA5, 1'b1);
    step;
    bus.D = 8'h5B;
    step;
    st("par_ok", 8'hA5, 1'b1, 2);
    bus.CE = 1'b0;
    force dut.dat[1][0] = 1'b0;
    #1;
    chk("par_err", 32'(bus.PERR), 32'd1);
    release dut.dat[1][0];
    drv(1'b0, 1'b1, 8'h00, 1'b0);
    step;
    st("par_fl", RV, 1'b0, 0);
`endif

    // async reset mid-cycle with full pipe
    drv(1'b1, 1'b0, 8'h9A, 1'b1);
    step;
    bus.D = 8'hAB;
    step;
    st("pre_ar", 8'h9A, 1'b1, 2);
    #2;
    RST = 1'b1;
    #1;
    st("async_rst", RV, 1'b0, 0);
    #3;
    RST = 1'b0;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    step;
    st("post_ar", RV, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
